encoder_4to2_seq: RTL and testbench

- Registered, handshaked encoder: the inverse of the team's 2-to-4 line decoder.
- Captures event strobes on N request lines into a sticky pending register.
- Emits one binary index per pending line over a valid/ready interface.
- Sits between one-hot/multi-hot event sources and any consumer of binary codes (e.g. a decoder downstream).

---
 rtl/encoder_4to2_seq.sv | 152 +++++++++++++++
 tb/tb_encoder_4to2_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/encoder_4to2_seq.sv
// encoder_4to2_seq: sticky-pending, valid/ready encoder of N request strobes to a W-bit index.
// Define ENCODER_ROUND_ROBIN_EN for rotating priority; default is fixed lowest-index priority.
module encoder_4to2_seq #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic [W-1:0] out_idx,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] pending,
   output logic         drop
);

   if (N < 2 || N > 16) begin : g_bad_n
      $error("encoder_4to2_seq: N must be in 2..16");
   end
   if (W != $clog2(N)) begin : g_bad_w
      $error("encoder_4to2_seq: W must equal clog2(N)");
   end

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t       state_q, state_d;
   logic [N-1:0] pending_q, pending_d;
   logic [W-1:0] idx_q, idx_d;
   logic         drop_q, drop_d;
   logic         accept;
   logic [N-1:0] clr;
   logic [N-1:0] rem;
   logic [W-1:0] sel_pend;
   logic [W-1:0] sel_rem;

`ifdef ENCODER_ROUND_ROBIN_EN
   logic [W-1:0] ptr_q, ptr_d;

   // Lowest distance from base+1 (mod N) wins; base itself ranks last.
   function automatic logic [W-1:0] pick(input logic [N-1:0] vec, input logic [W-1:0] base);
      logic [W-1:0] res;
      int unsigned  b;
      int unsigned  d;
      int unsigned  best_d;
      res    = '0;
      b      = 32'(base);
      best_d = N;
      for (int unsigned i = 0; i < N; i++) begin
         d = (i + N - 1 - b) % N;
         if (vec[i] && d < best_d) begin
            best_d = d;
            res    = W'(i);
         end
      end
      return res;
   endfunction

   always_comb begin
      sel_pend = pick(pending_q, ptr_q);
      sel_rem  = pick(rem, idx_q);
   end
`else
   function automatic logic [W-1:0] pick(input logic [N-1:0] vec);
      logic [W-1:0] res;
      logic         found;
      res   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (vec[i] && !found) begin
            res   = W'(i);
            found = 1'b1;
         end
      end
      return res;
   endfunction

   always_comb begin
      sel_pend = pick(pending_q);
      sel_rem  = pick(rem);
   end
`endif

   // New strobes are OR-ed in after the clear, so a re-request on the accept edge survives.
   always_comb begin
      accept = (state_q == HOLD) && out_ready;
      clr    = '0;
      for (int unsigned i = 0; i < N; i++) begin
         clr[i] = accept && (idx_q == W'(i));
      end
      rem       = pending_q & ~clr;
      pending_d = rem | req;
      drop_d    = |(req & rem);
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
`ifdef ENCODER_ROUND_ROBIN_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (|pending_q) begin
               state_d = HOLD;
               idx_d   = sel_pend;
            end
         end
         HOLD: begin
            if (accept) begin
`ifdef ENCODER_ROUND_ROBIN_EN
               ptr_d = idx_q;
`endif
               if (|rem) begin
                  idx_d = sel_rem;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
         idx_q     <= '0;
         drop_q    <= 1'b0;
`ifdef ENCODER_ROUND_ROBIN_EN
         ptr_q     <= W'(N - 1);
`endif
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         idx_q     <= idx_d;
         drop_q    <= drop_d;
`ifdef ENCODER_ROUND_ROBIN_EN
         ptr_q     <= ptr_d;
`endif
      end
   end

   assign out_idx   = idx_q;
   assign out_valid = (state_q == HOLD);
   assign pending   = pending_q;
   assign drop      = drop_q;

endmodule

// File: tb/tb_encoder_4to2_seq.sv
// tb_encoder_4to2_seq: directed scenarios then random traffic, checked against a behavioural model.
module tb_encoder_4to2_seq;
   localparam int unsigned N = 4;
   localparam int unsigned W = 2;
`ifdef ENCODER_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic [W-1:0] out_idx;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] pending;
   logic         drop;

   int checks = 0;
   int errors = 0;

   bit [N-1:0]   m_pend;
   bit           m_valid;
   int unsigned  m_idx;
   bit           m_drop;
   int unsigned  m_ptr;
   logic [W-1:0] acc_log[$];

   always #5 clk = ~clk;

   encoder_4to2_seq #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .out_idx   (out_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pending   (pending),
      .drop      (drop)
   );

   // First set line found walking upward from last+1 with wrap-around.
   function automatic int unsigned pick(input bit [N-1:0] v, input int unsigned last);
      int unsigned j;
      for (int unsigned k = 1; k <= N; k++) begin
         j = (last + k) % N;
         if (v[j]) return j;
      end
      return 0;
   endfunction

   task automatic model_edge(input bit [N-1:0] r, input bit rdy, input bit rs);
      bit [N-1:0]  clrm;
      bit [N-1:0]  left;
      int unsigned base;
      if (rs) begin
         m_pend  = '0;
         m_valid = 1'b0;
         m_idx   = 0;
         m_drop  = 1'b0;
         m_ptr   = N - 1;
         return;
      end
      clrm   = (m_valid && rdy) ? (N'(1) << m_idx) : '0;
      left   = m_pend & ~clrm;
      m_drop = |(r & left);
      if (!m_valid) begin
         if (m_pend != 0) begin
            base    = RR ? m_ptr : N - 1;
            m_idx   = pick(m_pend, base);
            m_valid = 1'b1;
         end
      end else if (rdy) begin
         base = RR ? m_idx : N - 1;
         if (RR) m_ptr = m_idx;
         if (left != 0) m_idx = pick(left, base);
         else m_valid = 1'b0;
      end
      m_pend = left | r;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [N-1:0] r, input logic rdy, input logic rs);
      @(negedge clk);
      req       = r;
      out_ready = rdy;
      rst       = rs;
      if (!rs && rdy && out_valid === 1'b1) acc_log.push_back(out_idx);
      @(posedge clk);
      model_edge(r, rdy, rs);
      #1;
      chk("model_pending", 32'(pending), 32'(m_pend));
      chk("model_valid", 32'(out_valid), 32'(m_valid));
      chk("model_idx", 32'(out_idx), m_idx);
      chk("model_drop", 32'(drop), 32'(m_drop));
   endtask

   initial begin
      rst       = 1'b1;
      req       = '0;
      out_ready = 1'b0;

      // reset; requests during reset are ignored
      step(4'b0000, 1'b0, 1'b1);
      step(4'b1111, 1'b1, 1'b1);
      chk("rst_pending", 32'(pending), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_idx", 32'(out_idx), 0);
      chk("rst_drop", 32'(drop), 0);

      // single event: valid two edges after the pulse, for one cycle
      step(4'b0100, 1'b1, 1'b0);
      chk("single_lat1_valid", 32'(out_valid), 0);
      step(4'b0000, 1'b1, 1'b0);
      chk("single_valid", 32'(out_valid), 1);
      chk("single_idx", 32'(out_idx), 2);
      step(4'b0000, 1'b1, 1'b0);
      chk("single_done_valid", 32'(out_valid), 0);
      chk("single_done_pend", 32'(pending), 0);

      // backpressure holds index 1, then 1 and 3 go back-to-back
      step(4'b1010, 1'b0, 1'b0);
      repeat (5) begin
         step(4'b0000, 1'b0, 1'b0);
         chk("bp_hold_valid", 32'(out_valid), 1);
         chk("bp_hold_idx", 32'(out_idx), 1);
      end
      step(4'b0000, 1'b1, 1'b0);
      chk("bp_second_idx", 32'(out_idx), 3);
      step(4'b0000, 1'b1, 1'b0);
      chk("bp_drained", 32'(out_valid), 0);
      chk("bp_idx_kept", 32'(out_idx), 3);

      // merge into pending bit 0 pulses drop once; only one index 0 emitted
      step(4'b0001, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0001, 1'b0, 1'b0);
      chk("drop_pulse", 32'(drop), 1);
      step(4'b0000, 1'b0, 1'b0);
      chk("drop_clear", 32'(drop), 0);
      step(4'b0000, 1'b1, 1'b0);
      chk("merge_done_valid", 32'(out_valid), 0);
      chk("merge_done_pend", 32'(pending), 0);

      // re-request on the accept edge re-arms the same line
      step(4'b0100, 1'b1, 1'b0);
      step(4'b0000, 1'b1, 1'b0);
      step(4'b0100, 1'b1, 1'b0);
      chk("sbc_pending", 32'(pending), 4);
      step(4'b0000, 1'b1, 1'b0);
      chk("sbc_reemit_valid", 32'(out_valid), 1);
      chk("sbc_reemit_idx", 32'(out_idx), 2);
      step(4'b0000, 1'b1, 1'b0);

      // reset while busy discards everything
      step(4'b1111, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      chk("mid_busy_valid", 32'(out_valid), 1);
      step(4'b1111, 1'b0, 1'b1);
      chk("mid_rst_pending", 32'(pending), 0);
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_idx", 32'(out_idx), 0);
      chk("mid_rst_drop", 32'(drop), 0);

      // all lines held: rotation under round robin, lines 0/1 alternate under fixed priority
      acc_log.delete();
      repeat (13) step(4'b1111, 1'b1, 1'b0);
      chk("fair_count", 32'(acc_log.size()), 11);
      for (int k = 0; k < acc_log.size(); k++) begin
         chk("fair_seq", 32'(acc_log[k]), RR ? 32'(k % 4) : 32'(k % 2));
      end

      // random traffic with occasional reset
      for (int n = 0; n < 400; n++) begin
         logic [N-1:0] r;
         r = N'($urandom) & N'($urandom);
         step(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
